prog_loader: RTL and testbench

//   Upstream stage of the FSM controller's program path. Receives a framed byte stream from
//   the host pins, buffers and checksums it, then replays it to the controller. The replay

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/loader_buffer.sv | 27 ++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_FILL,
    ST_CHECK,
    ST_BURST
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DEFAULT_MAGIC   = 8'hA5;
  localparam int         DEFAULT_MAX_LEN = 64;
  localparam int         DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/loader_buffer.sv
// Payload store: one synchronous write port, one read port with a registered output.
// Contents are deliberately left untouched by reset.
module loader_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/prog_loader.sv
// Framed program loader: MAGIC, LEN, payload, XOR checksum in; a verified payload is
// replayed one byte per clock with prog_enable high, starting the cycle after CSUM.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         MAX_LEN = DEFAULT_MAX_LEN,
  parameter logic [7:0] MAGIC   = DEFAULT_MAGIC,
  parameter int         TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  input  logic [7:0] run_data,
  output logic       prog_enable,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       loaded,
  output logic [1:0] err_code
);

  localparam int         PW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        r_state;
  logic [PW-1:0] r_len;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [7:0]    r_csum;
  logic [TW-1:0] r_idle_cnt;
  logic          r_prog_enable;
  logic          r_done;
  logic          r_loaded;
  logic [1:0]    r_err;

  logic          w_in_frame;
  logic          w_timeout;
  logic          w_wr_en;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_rd_data;

  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_FILL) || (r_state == ST_CHECK);
  assign w_timeout  = (TIMEOUT != 0) && w_in_frame && !host_valid &&
                      (r_idle_cnt == TW'(TIMEOUT - 1));
  assign w_wr_en    = (r_state == ST_FILL) && host_valid;
  // Address 0 outside BURST so buf[0] is already in the read register when the burst starts.
  assign w_rd_addr  = (r_state == ST_BURST) ? r_rd_ptr[AW-1:0] : '0;

  loader_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buffer (
    .clock     (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (host_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_csum        <= '0;
      r_idle_cnt    <= '0;
      r_prog_enable <= 1'b0;
      r_done        <= 1'b0;
      r_loaded      <= 1'b0;
      r_err         <= ERR_OK;
    end else begin
      r_done <= 1'b0;

      if (w_in_frame) begin
        r_idle_cnt <= host_valid ? '0 : r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end

      if (w_timeout) begin
        r_err   <= ERR_TIMEOUT;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (host_valid && host_data == MAGIC) begin
              r_err   <= ERR_OK;
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (host_valid) begin
              if (host_data == 8'd0 || host_data > MAX_LEN_B) begin
                r_err   <= ERR_LEN;
                r_state <= ST_IDLE;
              end else begin
                r_len    <= PW'(host_data);
                r_wr_ptr <= '0;
                r_csum   <= '0;
                r_state  <= ST_FILL;
              end
            end
          end
          ST_FILL: begin
            if (host_valid) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_csum   <= r_csum ^ host_data;
              if (r_wr_ptr + PW'(1) == r_len) begin
                r_state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (host_valid) begin
              if (host_data == r_csum) begin
                r_prog_enable <= 1'b1;
                r_rd_ptr      <= PW'(1);
                r_state       <= ST_BURST;
              end else begin
                r_err   <= ERR_CSUM;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_BURST: begin
            // r_rd_ptr runs one ahead of the byte on data_out; host bytes are dropped here.
            if (r_rd_ptr == r_len) begin
              r_prog_enable <= 1'b0;
              r_done        <= 1'b1;
              r_loaded      <= 1'b1;
              r_state       <= ST_IDLE;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign prog_enable = r_prog_enable;
  assign data_out    = r_prog_enable ? w_rd_data : run_data;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign loaded      = r_loaded;
  assign err_code    = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame-level reference model with per-cycle comparison,
// directed scenarios with literal expectations, then randomized frames.
module tb_prog_loader;

  localparam int         MAXL = 64;
  localparam int         TO   = 16;
  localparam logic [7:0] MG   = 8'hA5;

  logic       clock;
  logic       rst_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic [7:0] run_data;
  logic       prog_enable;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       loaded;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  prog_loader #(
    .MAX_LEN (MAXL),
    .MAGIC   (MG),
    .TIMEOUT (TO)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .host_valid  (host_valid),
    .host_data   (host_data),
    .run_data    (run_data),
    .prog_enable (prog_enable),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .loaded      (loaded),
    .err_code    (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes of a frame after MAGIC and decides at frame end.
  logic [7:0] m_frame[$];
  logic [7:0] m_burst[$];
  bit         m_in_frame;
  bit         m_bursting;
  bit         m_done;
  bit         m_loaded;
  logic [1:0] m_err;
  int         m_idle;

  task automatic model_reset();
    m_frame.delete();
    m_burst.delete();
    m_in_frame = 1'b0;
    m_bursting = 1'b0;
    m_done     = 1'b0;
    m_loaded   = 1'b0;
    m_err      = 2'b00;
    m_idle     = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] cs;
    int         n;
    m_done = 1'b0;
    if (m_bursting) begin
      void'(m_burst.pop_front());
      if (m_burst.size() == 0) begin
        m_bursting = 1'b0;
        m_done     = 1'b1;
        m_loaded   = 1'b1;
      end
    end else if (!m_in_frame) begin
      if (v && d == MG) begin
        m_in_frame = 1'b1;
        m_frame.delete();
        m_idle = 0;
        m_err  = 2'b00;
      end
    end else if (!v) begin
      m_idle++;
      if (m_idle == TO) begin
        m_in_frame = 1'b0;
        m_err      = 2'b11;
      end
    end else begin
      m_idle = 0;
      m_frame.push_back(d);
      n = int'(m_frame[0]);
      if (m_frame.size() == 1 && (n == 0 || n > MAXL)) begin
        m_in_frame = 1'b0;
        m_err      = 2'b01;
      end else if (m_frame.size() == n + 2) begin
        cs = 8'h00;
        for (int i = 1; i <= n; i++) cs ^= m_frame[i];
        m_in_frame = 1'b0;
        if (cs == d) begin
          m_burst.delete();
          for (int i = 1; i <= n; i++) m_burst.push_back(m_frame[i]);
          m_bursting = 1'b1;
        end else begin
          m_err = 2'b10;
        end
      end
    end
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(host_valid, host_data);
  end

  // Per-cycle comparison plus a record of what the controller actually received.
  bit         cmp_en = 1'b0;
  logic [7:0] seen[$];
  int         done_cnt = 0;

  task automatic compare_all();
    check("prog_enable", 8'(prog_enable), 8'(m_bursting));
    check("data_out", data_out, m_bursting ? m_burst[0] : run_data);
    check("busy", 8'(busy), 8'(m_in_frame || m_bursting));
    check("done", 8'(done), 8'(m_done));
    check("loaded", 8'(loaded), 8'(m_loaded));
    check("err_code", 8'(err_code), 8'(m_err));
    if (prog_enable) seen.push_back(data_out);
    if (done) done_cnt++;
  endtask

  always @(negedge clock) begin
    if (cmp_en && rst_n) compare_all();
  end

  function automatic logic [7:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 8'hEE;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clock);
    #2;
    host_valid = v;
    host_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) drive(1'b1, b[i]);
  endtask

  task automatic sample_point();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] fr[$];
  int         kind;
  int         len;
  int         start_done;
  logic [7:0] b;
  logic [7:0] cs;

  initial begin
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;
    run_data   = 8'h00;

    // Reset state
    sample_point();
    check("rst_prog_enable", 8'(prog_enable), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    check("rst_loaded", 8'(loaded), 8'h00);
    check("rst_err", 8'(err_code), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_data_out", data_out, 8'h00);
    @(posedge clock);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Good 3-byte frame
    seen.delete();
    start_done = done_cnt;
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send(fr);
    idle(6);
    check("t1_burst_len", 8'(seen.size()), 8'd3);
    check("t1_byte0", seen_at(0), 8'h11);
    check("t1_byte1", seen_at(1), 8'h22);
    check("t1_byte2", seen_at(2), 8'h33);
    check("t1_done_pulses", 8'(done_cnt - start_done), 8'd1);
    check("t1_loaded", 8'(loaded), 8'h01);
    check("t1_err", 8'(err_code), 8'h00);

    // Bad checksum
    seen.delete();
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
    send(fr);
    idle(4);
    check("t2_err", 8'(err_code), 8'h02);
    check("t2_no_burst", 8'(seen.size()), 8'd0);
    check("t2_loaded", 8'(loaded), 8'h01);

    // Bad lengths
    fr = '{8'hA5, 8'h00};
    send(fr);
    idle(2);
    check("t3_len0_err", 8'(err_code), 8'h01);
    check("t3_len0_busy", 8'(busy), 8'h00);
    fr = '{8'hA5, 8'h41};
    send(fr);
    idle(2);
    check("t3_len65_err", 8'(err_code), 8'h01);
    check("t3_len65_busy", 8'(busy), 8'h00);

    // Timeout after exactly TO idle cycles
    fr = '{8'hA5, 8'h02, 8'h7E};
    send(fr);
    idle(TO - 1);
    sample_point();
    check("t4_before_to_busy", 8'(busy), 8'h01);
    check("t4_before_to_err", 8'(err_code), 8'h00);
    sample_point();
    check("t4_to_err", 8'(err_code), 8'h03);
    check("t4_to_busy", 8'(busy), 8'h00);
    seen.delete();
    fr = '{8'hA5, 8'h01, 8'h3C, 8'h3C};
    send(fr);
    idle(4);
    check("t4_recover_err", 8'(err_code), 8'h00);
    check("t4_recover_byte", seen_at(0), 8'h3C);

    // Reset in burst cycle 2 of a 4-byte frame
    fr = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send(fr);
    drive(1'b0, 8'h00);
    @(posedge clock);
    @(posedge clock);
    #2;
    check("t5_burst_k2_en", 8'(prog_enable), 8'h01);
    check("t5_burst_k2_data", data_out, 8'h03);
    rst_n = 1'b0;
    #1;
    check("t5_rst_prog_enable", 8'(prog_enable), 8'h00);
    check("t5_rst_loaded", 8'(loaded), 8'h00);
    check("t5_rst_busy", 8'(busy), 8'h00);
    @(posedge clock);
    #2;
    rst_n = 1'b1;

    // Pass-through between frames, stray bytes, host bytes during a burst
    run_data = 8'h5A;
    fr = '{8'h00, 8'hFF};
    send(fr);
    drive(1'b0, 8'h00);
    sample_point();
    check("t6_passthru", data_out, 8'h5A);
    check("t6_busy", 8'(busy), 8'h00);
    check("t6_err", 8'(err_code), 8'h00);
    seen.delete();
    fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'hA5, 8'h77};
    send(fr);
    idle(4);
    check("t6_burst_len", 8'(seen.size()), 8'd2);
    check("t6_byte0", seen_at(0), 8'h10);
    check("t6_byte1", seen_at(1), 8'h20);
    check("t6_loaded", 8'(loaded), 8'h01);
    check("t6_err_after", 8'(err_code), 8'h00);

    // Randomized frames: good, bad length, timeout, bad checksum
    for (int f = 0; f < 40; f++) begin
      kind     = $urandom_range(0, 9);
      len      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAXL) : $urandom_range(1, 6);
      run_data = 8'($urandom);
      drive(1'b1, MG);
      idle($urandom_range(0, 3));
      if (kind == 0) begin
        drive(1'b1, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      end else begin
        drive(1'b1, 8'(len));
        cs = 8'h00;
        for (int i = 0; i < len; i++) begin
          b  = 8'($urandom);
          cs = cs ^ b;
          drive(1'b1, b);
          idle($urandom_range(0, 2));
        end
        if (kind == 1) idle(TO + 2);
        else           drive(1'b1, (kind == 2) ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
      end
      for (int i = 0; i < len + 4; i++) begin
        b = 8'($urandom);
        if (b == MG) b = 8'h5A;
        drive($urandom_range(0, 3) == 0, b);
      end
      run_data = 8'($urandom);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
